// File: rtl/hazard_pkg.sv
// Shared constants and width helpers for the hazard scoreboard.
package hazard_pkg;

    // Forwarding select value meaning "read from the register file"
    localparam int unsigned FWD_REGFILE = 0;

    // Canonical result latencies
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    // Width of a latency countdown able to hold 0..max_lat
    function automatic int unsigned hz_lat_width(input int unsigned max_lat);
        return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
    endfunction

    // Width of a forwarding select able to hold 0..fwd_stages
    function automatic int unsigned hz_fwd_width(input int unsigned fwd_stages);
        return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
    endfunction

    // Width of the flush counter holding 0..depth-1 (at least one bit)
    function automatic int unsigned hz_cnt_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hz_countdown_array.sv
// Per-register pending-write latency countdowns with compare and read ports.
module hz_countdown_array
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LW       = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    // Load port: start a countdown for one register
    input  logic                i_load_en,
    input  logic [REG_AW-1:0]   i_load_addr,
    input  logic [LW-1:0]       i_load_val,
    // Read ports: rs, rt and rd of the ID instruction
    input  logic [REG_AW-1:0]   i_rd_addr_a,
    input  logic [REG_AW-1:0]   i_rd_addr_b,
    input  logic [REG_AW-1:0]   i_rd_addr_c,
    output logic [LW-1:0]       o_pend_a,
    output logic [LW-1:0]       o_pend_b,
    output logic [LW-1:0]       o_pend_c,
    // Equality of every countdown with a latency value
    input  logic [LW-1:0]       i_cmp_val,
    output logic [NUM_REGS-1:0] o_eq_vec,
    // Register whose countdown goes 1 -> 0 on the coming edge
    output logic                o_done_valid,
    output logic [REG_AW-1:0]   o_done_addr,
    output logic                o_any
);

    logic [LW-1:0] r_pend [NUM_REGS];

    // Countdown update: a load wins over the decrement; register 0 stays idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            r_pend[0] <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (i_load_en && (i_load_addr == REG_AW'(r))) begin
                    r_pend[r] <= i_load_val;
                end else if (r_pend[r] != '0) begin
                    r_pend[r] <= r_pend[r] - LW'(1);
                end
            end
        end
    end

    assign o_pend_a = r_pend[i_rd_addr_a];
    assign o_pend_b = r_pend[i_rd_addr_b];
    assign o_pend_c = r_pend[i_rd_addr_c];

    // Compare vector, completion encoder and any-pending reduction
    always_comb begin
        o_eq_vec     = '0;
        o_done_valid = 1'b0;
        o_done_addr  = '0;
        o_any        = 1'b0;
        // Descending scan so the lowest index wins; the collision rule keeps
        // completions to at most one per edge anyway.
        for (int r = int'(NUM_REGS) - 1; r >= 1; r--) begin
            o_eq_vec[r] = (r_pend[r] == i_cmp_val);
            if (r_pend[r] != '0) begin
                o_any = 1'b1;
            end
            if (r_pend[r] == LW'(LAT_ALU)) begin
                o_done_valid = 1'b1;
                o_done_addr  = REG_AW'(r);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside ID: stall, flush, issue and EX forwarding selects.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MAX_LAT     = 4,
    parameter int unsigned FWD_STAGES  = 2,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_id_valid,
    input  logic [REG_AW-1:0]                     i_id_rs,
    input  logic [REG_AW-1:0]                     i_id_rt,
    input  logic                                  i_id_use_rs,
    input  logic                                  i_id_use_rt,
    input  logic                                  i_id_wr_en,
    input  logic [REG_AW-1:0]                     i_id_rd,
    input  logic [hz_lat_width(MAX_LAT)-1:0]      i_id_lat,
    input  logic                                  i_redirect,
    output logic                                  o_stall,
    output logic                                  o_flush,
    output logic                                  o_issue,
    output logic [hz_fwd_width(FWD_STAGES)-1:0]   o_fwd_rs_sel,
    output logic [hz_fwd_width(FWD_STAGES)-1:0]   o_fwd_rt_sel,
    output logic                                  o_pending_any
);

    localparam int unsigned LW  = hz_lat_width(MAX_LAT);
    localparam int unsigned FW  = hz_fwd_width(FWD_STAGES);
    localparam int unsigned FCW = hz_cnt_width(FLUSH_DEPTH);

    // Completed-write history, index 0 is the youngest
    logic [FWD_STAGES-1:0] r_done_vld;
    logic [REG_AW-1:0]     r_done_rd [FWD_STAGES];
    logic [FCW-1:0]        r_fcnt;

    logic [LW-1:0]       w_lat;
    logic [LW-1:0]       w_pend_rs;
    logic [LW-1:0]       w_pend_rt;
    logic [LW-1:0]       w_pend_rd;
    logic [NUM_REGS-1:0] w_eq_vec;
    logic                w_cmp_valid;
    logic [REG_AW-1:0]   w_cmp_addr;
    logic                w_any;
    logic                w_raw;
    logic                w_coll;
    logic                w_waw;
    logic                w_flush;
    logic                w_stall;
    logic                w_issue;
    logic                w_wr_commit;
    logic                w_load_en;
    logic [LW-1:0]       w_load_val;
    logic                w_done0_vld;
    logic [REG_AW-1:0]   w_done0_rd;
    logic [FCW-1:0]      w_fcnt_d;

    // Latency 0 behaves as an ALU op and oversized values saturate, so the
    // countdown never holds a value the collision check cannot see.
    always_comb begin
        w_lat = i_id_lat;
        if (i_id_lat == '0) begin
            w_lat = LW'(LAT_ALU);
        end else if (i_id_lat > LW'(MAX_LAT)) begin
            w_lat = LW'(MAX_LAT);
        end
    end

    hz_countdown_array #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW),
        .LW       (LW)
    ) u_pend (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_en    (w_load_en),
        .i_load_addr  (i_id_rd),
        .i_load_val   (w_load_val),
        .i_rd_addr_a  (i_id_rs),
        .i_rd_addr_b  (i_id_rt),
        .i_rd_addr_c  (i_id_rd),
        .o_pend_a     (w_pend_rs),
        .o_pend_b     (w_pend_rt),
        .o_pend_c     (w_pend_rd),
        .i_cmp_val    (w_lat),
        .o_eq_vec     (w_eq_vec),
        .o_done_valid (w_cmp_valid),
        .o_done_addr  (w_cmp_addr),
        .o_any        (w_any)
    );

    // Youngest matching completed write wins; r0 and unused sources use the regfile
    function automatic logic [FW-1:0] fwd_pick(input logic use_src,
                                               input logic [REG_AW-1:0] src);
        logic [FW-1:0] sel;
        sel = FW'(FWD_REGFILE);
        if (use_src && (src != '0)) begin
            for (int k = int'(FWD_STAGES); k >= 1; k--) begin
                if (r_done_vld[k-1] && (r_done_rd[k-1] == src)) begin
                    sel = FW'(k);
                end
            end
        end
        return sel;
    endfunction

    // Hazard detection, flush priority and issue decision
    always_comb begin
        w_raw = (i_id_use_rs && (i_id_rs != '0) && (w_pend_rs != '0)) ||
                (i_id_use_rt && (i_id_rt != '0) && (w_pend_rt != '0));
        // r0 writes change no state, so they cannot collide or overwrite
        w_coll = i_id_wr_en && (i_id_rd != '0) && (|w_eq_vec);
        w_waw  = i_id_wr_en && (i_id_rd != '0) && (w_pend_rd >= w_lat);

        w_flush = i_redirect || (r_fcnt != '0);
        w_stall = i_id_valid && !w_flush && (w_raw || w_coll || w_waw);
        w_issue = i_id_valid && !w_stall && !w_flush;

        w_wr_commit = w_issue && i_id_wr_en && (i_id_rd != '0);
        w_load_en   = w_wr_commit && (w_lat != LW'(LAT_ALU));
        w_load_val  = w_lat - LW'(1);

        // An ALU issue and a countdown completion never coincide (collision stall)
        if (w_wr_commit && (w_lat == LW'(LAT_ALU))) begin
            w_done0_vld = 1'b1;
            w_done0_rd  = i_id_rd;
        end else begin
            w_done0_vld = w_cmp_valid;
            w_done0_rd  = w_cmp_valid ? w_cmp_addr : '0;
        end

        w_fcnt_d = r_fcnt;
        if (i_redirect) begin
            w_fcnt_d = FCW'(FLUSH_DEPTH - 1);
        end else if (r_fcnt != '0) begin
            w_fcnt_d = r_fcnt - FCW'(1);
        end
    end

    // Completed-write shift register feeding the forwarding muxes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_done_vld <= '0;
            for (int unsigned k = 0; k < FWD_STAGES; k++) begin
                r_done_rd[k] <= '0;
            end
        end else begin
            r_done_vld[0] <= w_done0_vld;
            r_done_rd[0]  <= w_done0_rd;
            for (int unsigned k = 1; k < FWD_STAGES; k++) begin
                r_done_vld[k] <= r_done_vld[k-1];
                r_done_rd[k]  <= r_done_rd[k-1];
            end
        end
    end

    // Flush counter: a redirect (re)loads it, otherwise it runs down to zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= w_fcnt_d;
        end
    end

    assign o_stall       = w_stall;
    assign o_flush       = w_flush;
    assign o_issue       = w_issue;
    assign o_fwd_rs_sel  = fwd_pick(i_id_use_rs, i_id_rs);
    assign o_fwd_rt_sel  = fwd_pick(i_id_use_rt, i_id_rt);
    assign o_pending_any = w_any;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr_en;
    logic [4:0] id_rd;
    logic [2:0] id_lat;
    logic       redirect;
    logic       stall;
    logic       flush;
    logic       issue;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       pending_any;

    int total = 0;
    int bad   = 0;

    hazard_scoreboard #(
        .NUM_REGS    (32),
        .REG_AW      (5),
        .MAX_LAT     (4),
        .FWD_STAGES  (2),
        .FLUSH_DEPTH (2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_use_rs   (id_use_rs),
        .i_id_use_rt   (id_use_rt),
        .i_id_wr_en    (id_wr_en),
        .i_id_rd       (id_rd),
        .i_id_lat      (id_lat),
        .i_redirect    (redirect),
        .o_stall       (stall),
        .o_flush       (flush),
        .o_issue       (issue),
        .o_fwd_rs_sel  (fwd_rs_sel),
        .o_fwd_rt_sel  (fwd_rt_sel),
        .o_pending_any (pending_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wr,
                          input logic [4:0] rd, input logic [2:0] lat);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_use_rs = urs;
        id_use_rt = urt;
        id_wr_en  = wr;
        id_rd     = rd;
        id_lat    = lat;
        #1;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stall/flush/issue triple packed as {stall, flush, issue}
    function automatic logic [2:0] sfi();
        return {stall, flush, issue};
    endfunction

    initial begin
        rst_n    = 1'b0;
        redirect = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state with all inputs low
        #12;
        check("reset_sfi", 32'(sfi()), 32'b000);
        check("reset_sel", {fwd_rs_sel, fwd_rt_sel}, 4'b0000);
        check("reset_pend", pending_any, 1'b0);
        rst_n = 1'b1;
        tick();

        // First instruction after reset, no prior writes
        set_id(1, 3, 4, 1, 1, 0, 0, 0);
        check("first_sfi", 32'(sfi()), 32'b001);
        check("first_sel", {fwd_rs_sel, fwd_rt_sel}, 4'b0000);
        check("first_pend", pending_any, 1'b0);
        tick();

        // ALU write r5, then consumer over three cycles
        set_id(1, 0, 0, 0, 0, 1, 5, 1);
        check("alu_issue", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 5, 5, 1, 1, 0, 0, 0);
        check("alu_t1_sel", {fwd_rs_sel, fwd_rt_sel}, 4'b0101);
        check("alu_t1_sfi", 32'(sfi()), 32'b001);
        check("alu_t1_pend", pending_any, 1'b0);
        tick();
        check("alu_t2_sel", {fwd_rs_sel, fwd_rt_sel}, 4'b1010);
        set_id(1, 5, 5, 1, 0, 0, 0, 0);
        check("alu_t2_unused_rt", {fwd_rs_sel, fwd_rt_sel}, 4'b1000);
        tick();
        check("alu_t3_sel", fwd_rs_sel, 2'd0);

        // Load r8: dependent stalls one cycle then forwards from stage 1
        set_id(1, 0, 0, 0, 0, 1, 8, 2);
        check("ld_issue", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 0, 8, 0, 1, 0, 0, 0);
        check("ld_t1_sfi", 32'(sfi()), 32'b100);
        check("ld_t1_pend", pending_any, 1'b1);
        tick();
        check("ld_t2_sfi", 32'(sfi()), 32'b001);
        check("ld_t2_sel", fwd_rt_sel, 2'd1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Port collision: L=4 r9 then L=3 r10
        set_id(1, 0, 0, 0, 0, 1, 9, 4);
        check("col_first", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 10, 3);
        check("col_stall", 32'(sfi()), 32'b100);
        tick();
        check("col_go", 32'(sfi()), 32'b001);
        check("col_pend", pending_any, 1'b1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        tick();
        check("col_drained", pending_any, 1'b0);

        // WAW on r7 and the r0 exemption
        set_id(1, 0, 0, 0, 0, 1, 7, 4);
        check("waw_first", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 7, 2);
        check("waw_p3", 32'(sfi()), 32'b100);
        set_id(1, 0, 0, 0, 0, 1, 0, 2);
        check("waw_r0", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 7, 2);
        check("waw_p2", 32'(sfi()), 32'b100);
        tick();
        check("waw_p1", 32'(sfi()), 32'b001);
        tick();
        set_id(1, 7, 0, 1, 0, 0, 0, 0);
        check("waw_new_pending", 32'(sfi()), 32'b100);
        tick();
        check("waw_new_done", 32'(sfi()), 32'b001);
        check("waw_new_fwd", fwd_rs_sel, 2'd1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 3);
        check("r0_issue", 32'(sfi()), 32'b001);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        check("r0_no_pend", pending_any, 1'b0);

        // Redirect over a RAW stall, then a second redirect extending flush
        set_id(1, 0, 0, 0, 0, 1, 11, 3);
        tick();
        set_id(1, 11, 0, 1, 0, 0, 0, 0);
        check("fl_raw", 32'(sfi()), 32'b100);
        redirect = 1'b1;
        #1;
        check("fl_t0", 32'(sfi()), 32'b010);
        tick();
        redirect = 1'b0;
        #1;
        check("fl_t1", 32'(sfi()), 32'b010);
        redirect = 1'b1;
        #1;
        check("fl_t1_re", 32'(sfi()), 32'b010);
        tick();
        redirect = 1'b0;
        #1;
        check("fl_t2", 32'(sfi()), 32'b010);
        tick();
        check("fl_t3", 32'(sfi()), 32'b001);
        check("fl_t3_sel", fwd_rs_sel, 2'd2);

        // Async reset in the middle of a flush with a pending write
        set_id(1, 0, 0, 0, 0, 1, 12, 4);
        tick();
        set_id(1, 12, 0, 1, 0, 0, 0, 0);
        redirect = 1'b1;
        #1;
        tick();
        redirect = 1'b0;
        #1;
        check("rst_pre_flush", flush, 1'b1);
        check("rst_pre_pend", pending_any, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_sfi", 32'(sfi()), 32'b001);
        check("rst_mid_pend", pending_any, 1'b0);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_after_sfi", 32'(sfi()), 32'b001);
        check("rst_after_sel", fwd_rs_sel, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
